// File: rtl/val2_shift_sequencer_if.sv
// Request/response bundle between execute control and the Val2 sequencer.
interface val2_shift_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              flush;
  logic              imm;
  logic              mem_en;
  logic [11:0]       shift_operand;
  logic [DATA_W-1:0] val_rm;
  logic              c_in;
  logic [DATA_W-1:0] val2;
  logic              c_out;
  logic              busy;
  logic              done;

  modport master (
    output start, flush, imm, mem_en,
    output shift_operand, val_rm, c_in,
    input  val2, c_out, busy, done
  );

  modport slave (
    input  start, flush, imm, mem_en,
    input  shift_operand, val_rm, c_in,
    output val2, c_out, busy, done
  );
endinterface

// File: rtl/val2_shift_sequencer.sv
// Bit-serial Val2 shifter: one shift step per clock instead of a barrel.
// start/busy/done handshake, flush aborts without a done pulse.
module val2_shift_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  val2_shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] K_LSL = 2'b00;
  localparam logic [1:0] K_LSR = 2'b01;
  localparam logic [1:0] K_ASR = 2'b10;
  localparam logic [1:0] K_ROR = 2'b11;

  state_t            state;
  logic [DATA_W-1:0] work;
  logic              carry;
  logic [4:0]        count;
  logic [1:0]        kind;
  logic [DATA_W-1:0] val2_q;
  logic              c_out_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W-1:0] dec_work;
  logic [4:0]        dec_cnt;
  logic [1:0]        dec_kind;
  logic [DATA_W-1:0] step_work;
  logic              step_carry;

  // Operand forms overlap, so this decode is priority ordered.
  always_comb begin
    dec_work = bus.val_rm;
    dec_cnt  = '0;
    dec_kind = bus.shift_operand[6:5];
    priority case (1'b1)
      bus.mem_en: begin
        dec_work = {{(DATA_W-12){1'b0}}, bus.shift_operand};
      end
      bus.imm: begin
        dec_work = {{(DATA_W-8){1'b0}}, bus.shift_operand[7:0]};
        dec_cnt  = {bus.shift_operand[11:8], 1'b0};
        dec_kind = K_ROR;
      end
      bus.shift_operand[4]: begin
        dec_cnt = '0;
      end
      default: begin
        dec_cnt = bus.shift_operand[11:7];
      end
    endcase
  end

  always_comb begin
    step_work  = work;
    step_carry = carry;
    unique case (kind)
      K_LSL: begin
        step_carry = work[DATA_W-1];
        step_work  = {work[DATA_W-2:0], 1'b0};
      end
      K_LSR: begin
        step_carry = work[0];
        step_work  = {1'b0, work[DATA_W-1:1]};
      end
      K_ASR: begin
        step_carry = work[0];
        step_work  = {work[DATA_W-1], work[DATA_W-1:1]};
      end
      K_ROR: begin
        step_carry = work[0];
        step_work  = {work[0], work[DATA_W-1:1]};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      work    <= '0;
      carry   <= 1'b0;
      count   <= '0;
      kind    <= K_LSL;
      val2_q  <= '0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            busy_q <= 1'b1;
            work   <= dec_work;
            carry  <= bus.c_in;
            count  <= dec_cnt;
            kind   <= dec_kind;
            if (dec_cnt == '0) begin
              state   <= DONE;
              val2_q  <= dec_work;
              c_out_q <= bus.c_in;
              done_q  <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            work  <= step_work;
            carry <= step_carry;
            count <= count - 5'd1;
            // Last step lands straight in the output registers.
            if (count == 5'd1) begin
              state   <= DONE;
              val2_q  <= step_work;
              c_out_q <= step_carry;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // A flush in the DONE cycle cancels the pulse but keeps val2.
  assign bus.val2  = val2_q;
  assign bus.c_out = c_out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q && !(state == DONE && bus.flush);

endmodule

// File: doc/val2_shift_sequencer.md
# val2_shift_sequencer

Multi-cycle sequencer for the execute-stage second-operand (Val2) path. It accepts a shifter operand request: 32-bit immediate rotate, register shift by immediate (LSL/LSR/ASR/ROR) or memory offset. It then produces Val2 and the shifter carry by shifting a working register one bit per clock. The block sits between the decode/execute control and the ALU. It trades latency for area by replacing a full barrel shifter, and uses a start/busy/done handshake.

## Interface
- DATA_W, 32, operand width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- flush  input  1  synchronous abort; returns to IDLE without done.
- imm  input  1  1 = immediate rotate form.
- mem_en  input  1  1 = memory offset form; has priority over imm.
- shift_operand  input  12  [11:8] rot, [7:0] imm8; or [11:7] amount, [6:5] type, [4] reg-shift flag.
- val_rm  input  DATA_W  Rm value.
- c_in  input  1  current CPSR C flag.
- val2  output  DATA_W  result; reset 0.
- c_out  output  1  shifter carry-out; reset 0.
- busy  output  1  high when state != IDLE; reset 0.
- done  output  1  one-cycle completion pulse; reset 0.

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE. val2, c_out, busy and done are all 0 on reset.
- Accept: start=1 in IDLE. The block latches mode, type, val_rm and c_in into working registers (work, carry) and sets count A.
- Mode decode at accept, in priority order:
  - mem_en=1: work = {20'b0, shift_operand}, A = 0.
  - imm=1: work = {24'b0, imm8}, A = 2*rot (0..30), direction ROR.
  - shift_operand[4]=1 (register-specified shift, unsupported): work = val_rm, A = 0.
  - Otherwise: work = val_rm, A = amount (0..31); type 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- If A = 0, the block goes IDLE→DONE and carry = c_in. An amount of 0 is pass-through for every type; there is no RRX.
- If A > 0, the block goes IDLE→SHIFT. Each SHIFT cycle performs one 1-bit step and decrements the count. When the count reaches 0 the block goes SHIFT→DONE.
- 1-bit steps:
  - LSL: carry ← work[31], work ← {work[30:0],0}.
  - LSR: carry ← work[0], work ← {0,work[31:1]}.
  - ASR: carry ← work[0], work ← {work[31],work[31:1]}.
  - ROR: carry ← work[0], work ← {work[0],work[31:1]}.
- DONE: val2 ← work and c_out ← carry (registered on entry), done=1. The block then goes DONE→IDLE unconditionally on the next edge.
- val2/c_out hold their last values until the next DONE. They are not cleared on leaving DONE.
- start while busy (SHIFT or DONE) is ignored and not queued.
- flush=1 in SHIFT or DONE: next state IDLE, done=0 (a DONE-cycle flush still lets the already-registered val2 remain). flush has priority over start in IDLE: a start presented with flush=1 is dropped.
- Async reset mid-operation: the block goes to IDLE immediately, all outputs go to 0, and the in-flight request is lost.

## Timing
- Start sampled at edge 0. done is high for exactly the one cycle following edge A (A = 0 gives done in the cycle after edge 0).
- Latency: A+1 cycles from the start cycle to the done cycle. Worst case is 32 (LSL #31).
- busy rises after edge 0 and falls after edge A+1. The earliest next accept is edge A+1 + 1 (start is sampled in IDLE).
- val2/c_out are valid from the done cycle onward.

## Test plan
- Immediate rotate: imm=1, shift_operand=12'h103, start → after edge 2, val2=0xC0000000, c_out=1, done for 1 cycle, busy for 3 cycles.
- LSL: val_rm=0x80000001, shift_operand=12'h080, c_in=0 → after edge 1, val2=0x00000002, c_out=1.
- ASR and ROR:
  - val_rm=0x80000000, shift_operand=12'h240 → after edge 4, val2=0xF8000000, c_out=0.
  - val_rm=0x000000FF, shift_operand=12'h460 (ROR #8) → after edge 8, val2=0xFF000000, c_out=1.
- Pass-through:
  - mem_en=1, shift_operand=12'hFFF, c_in=1 → after edge 0, val2=0x00000FFF, c_out=1.
  - shift_operand[4]=1, val_rm=0x12345678 → val2=0x12345678.
  - LSR #0 → val2=val_rm, c_out=c_in.
- Handshake abuse:
  - A start pulse during SHIFT is ignored: exactly one done, and the result is the first request's.
  - flush at edge 3 of ROR #8 → IDLE next cycle, no done, val2 keeps its previous value.
- Reset: rst asserted asynchronously mid-SHIFT → busy, done, val2 and c_out are 0 immediately. A new request after release completes normally.
